corefifo_wr_ptr_ctrl: RTL and testbench
=======================================

// Module: corefifo_wr_ptr_ctrl
// PURPOSE
//  Write-domain pointer and flag logic for the dual-clock FIFO.
//  - Accepts write requests and generates the RAM write enable and address.
//  - Registers the Gray-coded write pointer that feeds the read-domain double synchroniser.
//  - Consumes the read pointer after it has been synchronised into the write domain.
//  - From that pointer it produces full, almost-full, word count and overflow.
// PARAMETERS
//  ADDRWIDTH    3  RAM address width; depth = 2**ADDRWIDTH; pointers are ADDRWIDTH+1 bits; legal >= 2
//  AFULL_THRESH 6  afull asserts when word count >= this; legal 1 .. 2**ADDRWIDTH
// PORTS
//  clk            in   1            write-domain clock
//  aresetn        in   1            asynchronous reset, active-low
//  we             in   1            write request
//  rptr_gray_sync in   ADDRWIDTH+1  read pointer (Gray), already double-synchronised into clk
//  wen_ram        out  1            RAM write strobe = we & ~full (combinational)
//  waddr          out  ADDRWIDTH    RAM write address = wbin[ADDRWIDTH-1:0]
//  wptr_gray      out  ADDRWIDTH+1  registered Gray write pointer, to read-side synchroniser
//  full           out  1            FIFO full (registered)
//  afull          out  1            almost full (registered)
//  wr_count       out  ADDRWIDTH+1  words held, as seen from write side (registered)
//  overflow       out  1            1-cycle pulse: write attempted while full
// BEHAVIOUR
//  Reset
//  - aresetn low forces all state to 0: wbin, wptr_gray, full, afull, wr_count, overflow.
//  - Asynchronous assert, synchronous release on clk.
//  - Reset mid-operation discards all pointer state; the read side must be reset in the same window.
//  Write acceptance
//  - accept = we & ~full. Only accepted writes advance the pointer.
//  - A write while full is dropped: no pointer change; overflow = 1 on the next edge, for one cycle.
//  Next-state computation, all evaluated combinationally each cycle
//  - wbin_next  = wbin + accept, modulo 2**(ADDRWIDTH+1); wraps from all-ones to 0.
//  - wgray_next = (wbin_next >> 1) ^ wbin_next.
//  - rbin = Gray-to-binary of rptr_gray_sync, computed by XOR-prefix from the MSB.
//  - full_next: asserted when wgray_next equals rptr_gray_sync with its two MSBs inverted.
//  - cnt_next = wbin_next - rbin, modulo 2**(ADDRWIDTH+1). Range 0 .. 2**ADDRWIDTH.
//  - afull_next = (cnt_next >= AFULL_THRESH).
//  Registering
//  - On each clk edge: wbin, wptr_gray, full, afull and wr_count load their _next values.
//  - wptr_gray changes by exactly one bit per accepted write, and never glitches.
//  Latency
//  - full, afull and wr_count reflect an accepted write on the same edge that stores it.
//  - A write that fills the FIFO therefore sees full = 1 on the following cycle.
//  - Reads show up only after the read-side pointer crosses the synchroniser (>= 2 clk).
//  - So full and afull de-assert pessimistically: late, never early. No false "not full".
//  Simultaneous events
//  - Accepted write and a changing rptr_gray_sync in the same cycle: both go into *_next.
//  - Example: full_next = 0 and cnt_next unchanged when one word is written and one is read.
//  - we held high while full: overflow repeats every cycle; the pointer stays frozen.
//  Outputs
//  - wen_ram and waddr are combinational from we, full and wbin; not registered.
// TESTING (ADDRWIDTH=3, AFULL_THRESH=6, rptr_gray_sync held 0 unless noted)
//  1 Reset: aresetn=0 mid-burst -> all outputs 0 immediately; after release waddr=0, full=0.
//  2 Fill: we=1 for 8 cycles -> waddr 0..7; wr_count 1..8; afull rises after 6th write;
//    full=1 after 8th write; wptr_gray=4'b1100.
//  3 Overflow: while full, we=1 for 3 cycles -> overflow high 3 cycles; wen_ram=0;
//    wptr_gray stays 4'b1100.
//  4 Drain: from full, set rptr_gray_sync=4'b0011 (rbin=2) -> next edge full=0, wr_count=6, afull=1;
//    then 4'b0111 (rbin=5) -> wr_count=3, afull=0.
//  5 Wrap: 20 write/read pairs with rptr_gray_sync tracking wptr_gray at 2-cycle delay
//    -> wbin wraps 15->0; full never asserts; wr_count <= 2; every wptr_gray step changes 1 bit.
//  6 Simultaneous: wr_count=8, write presented and rptr advances by 1 in the same cycle
//    -> no write (full); next cycle full=0, wr_count=7; write then accepted.

Source files
------------

// File: rtl/corefifo_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// corefifo_wr_ptr_ctrl
//   Write-domain pointer and flag logic for a dual-clock FIFO. Accepts write
//   requests, drives the RAM write strobe/address, keeps the binary write
//   pointer, and publishes its Gray-coded form to the read-side synchroniser.
//   The already-synchronised read pointer (Gray) is decoded here to derive
//   full, almost-full, word count and an overflow pulse.
//
// Ports
//   clk            in   write-domain clock
//   aresetn        in   asynchronous reset, active-low
//   we             in   write request
//   rptr_gray_sync in   read pointer (Gray), synchronised into clk
//   wen_ram        out  RAM write strobe, we & ~full (combinational)
//   waddr          out  RAM write address, low bits of binary write pointer
//   wptr_gray      out  registered Gray write pointer
//   full           out  FIFO full (registered)
//   afull          out  word count >= AFULL_THRESH (registered)
//   wr_count       out  words held as seen from the write side (registered)
//   overflow       out  one-cycle pulse: write attempted while full
//
// Handshake: a write is taken on a clk edge when we=1 and full=0 in the
// cycle before that edge (wen_ram=1); with full=1 the request is dropped and
// overflow pulses on that edge instead. There is no back-pressure beyond full.
// ---------------------------------------------------------------------------
module corefifo_wr_ptr_ctrl #(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rptr_gray_sync,
  output logic                 wen_ram,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   wr_count,
  output logic                 overflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [ADDRWIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [ADDRWIDTH:0] wbin;
  logic [ADDRWIDTH:0] wbin_next;
  logic [ADDRWIDTH:0] wgray_next;
  logic [ADDRWIDTH:0] rbin;
  logic [ADDRWIDTH:0] rgray_full;
  logic [ADDRWIDTH:0] cnt_next;
  logic               accept;
  logic               full_next;
  logic               afull_next;
  logic               gray_acc;

  assign accept  = we & ~full;
  assign wen_ram = accept;
  assign waddr   = wbin[ADDRWIDTH-1:0];

  always_comb begin
    wbin_next  = wbin + PW'(accept);
    wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    rbin     = '0;
    gray_acc = 1'b0;
    for (int i = ADDRWIDTH; i >= 0; i--) begin
      gray_acc = gray_acc ^ rptr_gray_sync[i];
      rbin[i]  = gray_acc;
    end

    // In Gray code, "write pointer exactly one lap ahead" is the read pointer
    // with its two MSBs flipped; all lower bits match.
    rgray_full = {~rptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rptr_gray_sync[ADDRWIDTH-2:0]};
    full_next  = (wgray_next == rgray_full);

    cnt_next   = wbin_next - rbin;
    afull_next = (cnt_next >= AFULL_LVL);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      afull     <= 1'b0;
      wr_count  <= '0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      full      <= full_next;
      afull     <= afull_next;
      wr_count  <= cnt_next;
      overflow  <= we & full;
    end
  end

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_corefifo_wr_ptr_ctrl
//   Bench for corefifo_wr_ptr_ctrl (ADDRWIDTH=3, AFULL_THRESH=6). The model
//   tracks absolute write and read word counts as plain integers; occupancy,
//   flags and the Gray pointer follow from those. Each stimulus step pushes
//   its expected response; a monitor pops and compares once per cycle.
// ---------------------------------------------------------------------------
module tb_corefifo_wr_ptr_ctrl;

  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int TH    = 6;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [PW-1:0] gray;
    logic          full;
    logic          afull;
    logic [PW-1:0] cnt;
    logic          ovf;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          aresetn;
  logic          we;
  logic [PW-1:0] rptr_gray_sync;
  logic          wen_ram;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          full;
  logic          afull;
  logic [PW-1:0] wr_count;
  logic          overflow;

  always #5 clk = ~clk;

  corefifo_wr_ptr_ctrl #(.ADDRWIDTH(AW), .AFULL_THRESH(TH)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .we             (we),
    .rptr_gray_sync (rptr_gray_sync),
    .wen_ram        (wen_ram),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .full           (full),
    .afull          (afull),
    .wr_count       (wr_count),
    .overflow       (overflow)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            m_wr   = 0;     // total accepted writes since reset
  logic          m_full = 1'b0;  // model of registered full
  logic          gray_prev_valid = 1'b0;
  logic [PW-1:0] gray_prev = '0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic logic [PW-1:0] to_gray(input int n);
    int m;
    m = n % (2 * DEPTH);
    return PW'(m ^ (m >> 1));
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive we and the read pointer (absolute read count rd_abs),
  // then record what the DUT must show before and after the coming edge.
  task automatic step(input logic w, input int rd_abs);
    exp_t e;
    logic acc;
    int   occ;
    @(negedge clk);
    we             = w;
    rptr_gray_sync = to_gray(rd_abs);
    acc     = w && !m_full;
    e.wen   = acc;
    e.waddr = AW'(m_wr % DEPTH);
    e.ovf   = w && m_full;
    if (acc) m_wr++;
    occ     = m_wr - rd_abs;
    e.full  = (occ == DEPTH);
    e.afull = (occ >= TH);
    e.cnt   = PW'(occ);
    e.gray  = to_gray(m_wr);
    m_full  = e.full;
    exp_q.push_back(e);
  endtask

  task automatic drain_wait();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", int'(exp_q.size()), 0);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic          s_wen;
    logic [AW-1:0] s_waddr;
    exp_t          e;
    forever begin
      @(negedge clk);
      #3;
      s_wen   = wen_ram;
      s_waddr = waddr;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wen_ram",   int'(s_wen),     int'(e.wen));
        if (e.wen) chk("waddr", int'(s_waddr), int'(e.waddr));
        chk("wptr_gray", int'(wptr_gray), int'(e.gray));
        chk("full",      int'(full),      int'(e.full));
        chk("afull",     int'(afull),     int'(e.afull));
        chk("wr_count",  int'(wr_count),  int'(e.cnt));
        chk("overflow",  int'(overflow),  int'(e.ovf));
        if (gray_prev_valid)
          chk("gray_one_bit_step", int'($countones(gray_prev ^ wptr_gray) <= 1), 1);
        gray_prev       = wptr_gray;
        gray_prev_valid = 1'b1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd;
    int lag1;
    int lag2;

    aresetn        = 1'b0;
    we             = 1'b0;
    rptr_gray_sync = '0;
    repeat (2) @(negedge clk);
    chk("rst_wptr_gray", int'(wptr_gray), 0);
    chk("rst_full",      int'(full),      0);
    chk("rst_afull",     int'(afull),     0);
    chk("rst_wr_count",  int'(wr_count),  0);
    chk("rst_overflow",  int'(overflow),  0);
    chk("rst_waddr",     int'(waddr),     0);
    aresetn = 1'b1;

    // Fill: eight writes, read side idle.
    rd = 0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, rd);
    // Overflow: three more writes while full.
    for (int i = 0; i < 3; i++) step(1'b1, rd);
    // Drain as seen through the synchroniser: rbin=2, then rbin=5.
    step(1'b0, 2);
    step(1'b0, 5);
    rd = 5;
    // Refill to full, then write together with a one-word read.
    for (int i = 0; i < 5; i++) step(1'b1, rd);
    rd = 6;
    step(1'b1, rd);
    step(1'b1, rd);
    drain_wait();
    chk("simul_full_after", int'(full), 1);

    // Wrap: read pointer follows the write pointer two cycles late.
    rd = m_wr;
    step(1'b0, rd);
    lag1 = m_wr;
    lag2 = m_wr;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, lag2);
      lag2 = lag1;
      lag1 = m_wr;
    end
    rd = lag2;

    // Random traffic: the read count only advances to values the write
    // side published at least two cycles earlier.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1 && rd < lag2) rd++;
      step(1'($urandom_range(0, 3) != 0), rd);
      lag2 = lag1;
      lag1 = m_wr;
    end

    // Mid-burst asynchronous reset.
    for (int i = 0; i < 3; i++) step(1'b1, rd);
    drain_wait();
    @(negedge clk);
    #2;
    aresetn = 1'b0;
    we      = 1'b0;
    #1;
    chk("async_rst_wptr_gray", int'(wptr_gray), 0);
    chk("async_rst_full",      int'(full),      0);
    chk("async_rst_afull",     int'(afull),     0);
    chk("async_rst_wr_count",  int'(wr_count),  0);
    chk("async_rst_overflow",  int'(overflow),  0);
    chk("async_rst_waddr",     int'(waddr),     0);
    chk("async_rst_wen_ram",   int'(wen_ram),   0);
    rptr_gray_sync  = '0;
    m_wr            = 0;
    m_full          = 1'b0;
    gray_prev_valid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("post_rst_waddr", int'(waddr), 0);
    chk("post_rst_full",  int'(full),  0);
    for (int i = 0; i < 4; i++) step(1'b1, 0);
    drain_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
